man_enc_frame: RTL and testbench

MAN_ENC_FRAME -- requirements
Module: man_enc_frame

---
 rtl/man_enc_frame.sv | 192 +++++++++++++++++++
 tb/tb_man_enc_frame.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/man_enc_frame.sv
// man_enc_frame -- framed Manchester encoder.
//
// Accepts one DATA_W-bit payload through a valid/ready handshake and sends
// it as an optional preamble of PRE_BITS ones followed by the payload, each
// bit split into two half-bits of HALF_DIV clock cycles. The line output is
// taken straight from a flop so it never glitches.
//
// Ports:
//   clk       in   single clock, all state changes on its rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   in_data holds a frame to send
//   in_ready  out  block is idle and will accept a frame this cycle
//   in_data   in   payload, captured on acceptance
//   out_data  out  registered Manchester line output
//   busy      out  frame in progress (preamble or payload)
//   done      out  one-cycle pulse in the first idle cycle after a frame
module man_enc_frame #(
  parameter int DATA_W    = 8,
  parameter int HALF_DIV  = 4,
  parameter int PRE_BITS  = 0,
  parameter int POLARITY  = 0,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_LVL  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_data,
  output logic              busy,
  output logic              done
);

  localparam int HC_W = $clog2(HALF_DIV + 1);
  // Wide enough for the largest bit count (32 payload bits).
  localparam int BC_W = 6;

  localparam logic [HC_W-1:0] HALF_LAST = HC_W'(HALF_DIV - 1);
  // Only used when PRE_BITS > 0; clamp so the constant stays well formed.
  localparam logic [BC_W-1:0] PRE_LAST  = BC_W'((PRE_BITS > 0) ? (PRE_BITS - 1) : 0);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);
  localparam logic            POL_BIT   = 1'(POLARITY);
  localparam logic            IDLE_BIT  = 1'(IDLE_LVL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // Line level for one half of a bit: a one is high-then-low at polarity 0.
  function automatic logic enc_half(input logic bit_v, input logic second_half);
    return bit_v ^ second_half ^ POL_BIT;
  endfunction

  // Bit of a payload word that goes out next in the configured order.
  function automatic logic first_bit(input logic [DATA_W-1:0] vec);
    if (MSB_FIRST != 0) begin
      return vec[DATA_W-1];
    end else begin
      return vec[0];
    end
  endfunction

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [HC_W-1:0]     r_half_cnt;
  logic                r_half_flag;
  logic [BC_W-1:0]     r_bit_cnt;
  logic                r_out;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [HC_W-1:0]     w_half_cnt_nxt;
  logic                w_half_flag_nxt;
  logic [BC_W-1:0]     w_bit_cnt_nxt;
  logic                w_out_nxt;
  logic                w_done_nxt;
  logic                w_busy_nxt;

  logic [DATA_W-1:0]   w_shifted;
  logic                w_cur_bit;
  logic                w_half_end;

  // Payload after dropping the bit just sent.
  assign w_shifted  = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
  assign w_cur_bit  = (r_state == S_PRE) ? 1'b1 : first_bit(r_shift);
  assign w_half_end = (r_half_cnt == HALF_LAST);

  // Next-state, counter and line-level decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_half_cnt_nxt  = r_half_cnt;
    w_half_flag_nxt = r_half_flag;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_out_nxt       = r_out;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_half_cnt_nxt  = {HC_W{1'b0}};
        w_half_flag_nxt = 1'b0;
        w_bit_cnt_nxt   = {BC_W{1'b0}};
        if (in_valid) begin
          // First half-bit is loaded here so it shows one cycle after accept.
          w_shift_nxt = in_data;
          w_state_nxt = (PRE_BITS > 0) ? S_PRE : S_DATA;
          w_out_nxt   = (PRE_BITS > 0) ? enc_half(1'b1, 1'b0)
                                       : enc_half(first_bit(in_data), 1'b0);
        end else begin
          w_state_nxt = S_IDLE;
          w_out_nxt   = IDLE_BIT;
        end
      end
      S_PRE, S_DATA: begin
        if (!w_half_end) begin
          w_half_cnt_nxt = r_half_cnt + HC_W'(1);
        end else if (!r_half_flag) begin
          // Mid-bit: move to the second half of the same bit.
          w_half_cnt_nxt  = {HC_W{1'b0}};
          w_half_flag_nxt = 1'b1;
          w_out_nxt       = enc_half(w_cur_bit, 1'b1);
        end else begin
          // Bit boundary: advance to the next bit, section or idle.
          w_half_cnt_nxt  = {HC_W{1'b0}};
          w_half_flag_nxt = 1'b0;
          if (r_state == S_PRE) begin
            if (r_bit_cnt == PRE_LAST) begin
              w_state_nxt   = S_DATA;
              w_bit_cnt_nxt = {BC_W{1'b0}};
              w_out_nxt     = enc_half(first_bit(r_shift), 1'b0);
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
              w_out_nxt     = enc_half(1'b1, 1'b0);
            end
          end else begin
            if (r_bit_cnt == DATA_LAST) begin
              w_state_nxt   = S_IDLE;
              w_bit_cnt_nxt = {BC_W{1'b0}};
              w_out_nxt     = IDLE_BIT;
              w_done_nxt    = 1'b1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
              w_shift_nxt   = w_shifted;
              w_out_nxt     = enc_half(first_bit(w_shifted), 1'b0);
            end
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_half_cnt_nxt  = {HC_W{1'b0}};
        w_half_flag_nxt = 1'b0;
        w_bit_cnt_nxt   = {BC_W{1'b0}};
        w_out_nxt       = IDLE_BIT;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= {DATA_W{1'b0}};
      r_half_cnt  <= {HC_W{1'b0}};
      r_half_flag <= 1'b0;
      r_bit_cnt   <= {BC_W{1'b0}};
      r_out       <= IDLE_BIT;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_half_cnt  <= w_half_cnt_nxt;
      r_half_flag <= w_half_flag_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_out       <= w_out_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign out_data = r_out;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_man_enc_frame.sv
// tb_man_enc_frame -- randomized bench for man_enc_frame.
//
// Four encoder instances with different parameter sets share one clock.
// Each frame is checked cycle by cycle against a line-level model derived
// from the frame layout: cycle k of a frame belongs to bit k/(2*HALF_DIV),
// half (k/HALF_DIV)%2; preamble bits are ones, payload bits follow in the
// configured order, and the half level follows the Manchester rule.
module tb_man_enc_frame;

  logic        clk;
  logic [3:0]  rst_n_s;
  logic [3:0]  vld_s;
  logic [3:0]  rdy_s;
  logic [3:0]  out_s;
  logic [3:0]  busy_s;
  logic [3:0]  done_s;
  logic [31:0] dat_s [4];

  // Parameter sets of the four instances, used by the reference model.
  int p_dw  [4] = '{8, 8, 8, 32};
  int p_hd  [4] = '{2, 2, 1, 255};
  int p_pre [4] = '{0, 0, 3, 0};
  int p_pol [4] = '{0, 1, 0, 0};
  int p_msb [4] = '{1, 0, 1, 1};
  int p_idl [4] = '{0, 0, 1, 0};

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  man_enc_frame #(.DATA_W(8), .HALF_DIV(2), .PRE_BITS(0), .POLARITY(0),
                  .MSB_FIRST(1), .IDLE_LVL(0)) u_a (
    .clk(clk), .rst_n(rst_n_s[0]), .in_valid(vld_s[0]), .in_ready(rdy_s[0]),
    .in_data(dat_s[0][7:0]), .out_data(out_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  man_enc_frame #(.DATA_W(8), .HALF_DIV(2), .PRE_BITS(0), .POLARITY(1),
                  .MSB_FIRST(0), .IDLE_LVL(0)) u_b (
    .clk(clk), .rst_n(rst_n_s[1]), .in_valid(vld_s[1]), .in_ready(rdy_s[1]),
    .in_data(dat_s[1][7:0]), .out_data(out_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  man_enc_frame #(.DATA_W(8), .HALF_DIV(1), .PRE_BITS(3), .POLARITY(0),
                  .MSB_FIRST(1), .IDLE_LVL(1)) u_c (
    .clk(clk), .rst_n(rst_n_s[2]), .in_valid(vld_s[2]), .in_ready(rdy_s[2]),
    .in_data(dat_s[2][7:0]), .out_data(out_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  man_enc_frame #(.DATA_W(32), .HALF_DIV(255), .PRE_BITS(0), .POLARITY(0),
                  .MSB_FIRST(1), .IDLE_LVL(0)) u_d (
    .clk(clk), .rst_n(rst_n_s[3]), .in_valid(vld_s[3]), .in_ready(rdy_s[3]),
    .in_data(dat_s[3]), .out_data(out_s[3]), .busy(busy_s[3]), .done(done_s[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level at cycle k (0 = first cycle after accept) of a frame.
  function automatic logic exp_level(input int u, input logic [31:0] d, input int k);
    int   b;
    int   h;
    int   j;
    logic bit_v;
    b = k / (2 * p_hd[u]);
    h = (k / p_hd[u]) % 2;
    if (b < p_pre[u]) begin
      bit_v = 1'b1;
    end else begin
      j = b - p_pre[u];
      bit_v = (p_msb[u] != 0) ? d[p_dw[u] - 1 - j] : d[j];
    end
    return (bit_v ? (h == 0) : (h == 1)) ^ (p_pol[u] != 0);
  endfunction

  // Offer frame d on unit u (called at a negedge while the unit is idle) and
  // check every cycle. With keep set, in_valid stays high through the frame
  // and the task returns at the done-cycle negedge so the next frame can be
  // offered in the done cycle itself.
  task automatic run_frame(input int u, input logic [31:0] d, input bit keep);
    int len;
    len = (p_pre[u] + p_dw[u]) * 2 * p_hd[u];
    dat_s[u] = d;
    vld_s[u] = 1'b1;
    check_eq($sformatf("u%0d ready_before_accept", u), 32'(rdy_s[u]), 32'd1);
    @(posedge clk);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check_eq($sformatf("u%0d out k%0d", u, k), 32'(out_s[u]), 32'(exp_level(u, d, k)));
      check_eq($sformatf("u%0d busy k%0d", u, k), 32'(busy_s[u]), 32'd1);
      check_eq($sformatf("u%0d done k%0d", u, k), 32'(done_s[u]), 32'd0);
      // Input noise while busy must neither start nor corrupt a frame.
      dat_s[u] = $urandom;
      vld_s[u] = keep ? 1'b1 : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check_eq($sformatf("u%0d done_pulse", u), 32'(done_s[u]), 32'd1);
    check_eq($sformatf("u%0d done_busy", u), 32'(busy_s[u]), 32'd0);
    check_eq($sformatf("u%0d done_out", u), 32'(out_s[u]), 32'(p_idl[u]));
    check_eq($sformatf("u%0d done_ready", u), 32'(rdy_s[u]), 32'd1);
    if (!keep) begin
      vld_s[u] = 1'b0;
      @(negedge clk);
      check_eq($sformatf("u%0d after_done", u), 32'(done_s[u]), 32'd0);
      check_eq($sformatf("u%0d after_busy", u), 32'(busy_s[u]), 32'd0);
      check_eq($sformatf("u%0d after_out", u), 32'(out_s[u]), 32'(p_idl[u]));
    end
  endtask

  // Abort a frame on unit 0 with reset after 10 cycles, then send a new one.
  task automatic reset_mid_frame();
    logic [31:0] d;
    d = $urandom;
    dat_s[0] = d;
    vld_s[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_pre out k%0d", k), 32'(out_s[0]), 32'(exp_level(0, d, k)));
      vld_s[0] = 1'($urandom_range(0, 1));
    end
    rst_n_s[0] = 1'b0;
    vld_s[0]   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_low out c%0d", k), 32'(out_s[0]), 32'(p_idl[0]));
      check_eq($sformatf("rst_low busy c%0d", k), 32'(busy_s[0]), 32'd0);
      check_eq($sformatf("rst_low done c%0d", k), 32'(done_s[0]), 32'd0);
    end
    rst_n_s[0] = 1'b1;
    vld_s[0]   = 1'b0;
    @(negedge clk);
    check_eq("rst_rel ready", 32'(rdy_s[0]), 32'd1);
    check_eq("rst_rel busy", 32'(busy_s[0]), 32'd0);
    check_eq("rst_rel done", 32'(done_s[0]), 32'd0);
    check_eq("rst_rel out", 32'(out_s[0]), 32'(p_idl[0]));
    run_frame(0, $urandom, 1'b0);
  endtask

  initial begin
    rst_n_s = 4'h0;
    vld_s   = 4'h0;
    for (int u = 0; u < 4; u++) dat_s[u] = 32'h0;
    repeat (3) @(negedge clk);
    // Valid asserted during reset must be ignored.
    vld_s = 4'hF;
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      check_eq($sformatf("u%0d reset_out", u), 32'(out_s[u]), 32'(p_idl[u]));
      check_eq($sformatf("u%0d reset_busy", u), 32'(busy_s[u]), 32'd0);
      check_eq($sformatf("u%0d reset_done", u), 32'(done_s[u]), 32'd0);
    end
    vld_s   = 4'h0;
    rst_n_s = 4'hF;
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      check_eq($sformatf("u%0d ready_after_reset", u), 32'(rdy_s[u]), 32'd1);
      check_eq($sformatf("u%0d idle_busy", u), 32'(busy_s[u]), 32'd0);
    end

    // Directed frames from the documented scenarios.
    run_frame(0, 32'h0000_00A5, 1'b0);
    run_frame(1, 32'h0000_0001, 1'b0);
    run_frame(2, 32'h0000_0000, 1'b0);

    // Back-to-back frames with in_valid held high.
    run_frame(0, $urandom, 1'b1);
    run_frame(0, $urandom, 1'b0);

    reset_mid_frame();

    // Random payloads, occasionally chained.
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 5; i++) begin
        run_frame(u, $urandom, (i < 4) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
    end

    // Widest payload with the slowest half-bit.
    run_frame(3, $urandom, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
